team_03_wb_arbiter: RTL

- Round-robin arbiter that shares the team's single Wishbone master port (toward SRAM and peripherals on the user bus) among NUM_REQ internal requesters.
- Candidate requesters: pixel fetch, command decoder, debug/LA port.
- Grants one requester at a time and holds the grant until ack, error timeout or requester abort.
- Gated by the project enable `en`; sits between team_03 core logic and the Wishbone master interface of the wrapper.

---
 rtl/team_03_wb_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/team_03_wb_arbiter.sv
// team_03_wb_arbiter
// Round-robin arbiter sharing one Wishbone master port among NUM_REQ
// internal requesters (pixel fetch, command decoder, debug/LA port).
// A grant is held until the slave acks, the transaction times out, the
// requester aborts, or the project enable drops. Exactly one IDLE cycle
// separates consecutive transactions.
module team_03_wb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = $clog2(TIMEOUT)
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   en,
   // requester side
   input  logic [NUM_REQ-1:0]     m_cyc_i,
   input  logic [NUM_REQ-1:0]     m_we_i,
   input  logic [NUM_REQ*32-1:0]  m_adr_i,
   input  logic [NUM_REQ*32-1:0]  m_dat_i,
   input  logic [NUM_REQ*4-1:0]   m_sel_i,
   output logic [NUM_REQ-1:0]     m_ack_o,
   output logic [NUM_REQ-1:0]     m_err_o,
   output logic [31:0]            m_dat_o,
   output logic [NUM_REQ-1:0]     grant_o,
   // Wishbone master side
   output logic                   wb_cyc_o,
   output logic                   wb_stb_o,
   output logic                   wb_we_o,
   output logic [31:0]            wb_adr_o,
   output logic [31:0]            wb_dat_o,
   output logic [3:0]             wb_sel_o,
   input  logic [31:0]            wb_dat_i,
   input  logic                   wb_ack_i,
   output logic                   busy_o
);

   localparam int              IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] CNT_MAX  = {TO_W{1'b1}};

   typedef enum logic {
      IDLE = 1'b0,
      BUS  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [TO_W-1:0]    cnt_q, cnt_d;

   logic [IDX_W-1:0]   sel_idx;
   logic               sel_vld;
   int                 rr_pos;

   logic [NUM_REQ-1:0] gnt_oh;
   logic               cyc_g;
   logic               we_mux;
   logic [31:0]        adr_mux;
   logic [31:0]        dat_mux;
   logic [3:0]         sel_mux;

   logic               bus_act;
   logic               xfer;
   logic               at_last;

   assign gnt_oh  = NUM_REQ'(1) << gnt_q;
   assign cyc_g   = |(m_cyc_i & gnt_oh);
   assign at_last = (cnt_q == CNT_LAST);

   // Round-robin search: first requesting index after the last one served.
   always_comb begin
      sel_idx = last_q;
      sel_vld = 1'b0;
      rr_pos  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_pos = (int'(last_q) + k) % NUM_REQ;
         if (!sel_vld && m_cyc_i[IDX_W'(rr_pos)]) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'(rr_pos);
         end
      end
   end

   // One-hot mux of the granted requester's bus signals.
   always_comb begin
      we_mux  = 1'b0;
      adr_mux = '0;
      dat_mux = '0;
      sel_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_oh[i]) begin
            we_mux  = m_we_i[i];
            adr_mux = m_adr_i[32*i +: 32];
            dat_mux = m_dat_i[32*i +: 32];
            sel_mux = m_sel_i[4*i +: 4];
         end
      end
   end

   // Next-state logic; BUS exits are disable, abort, ack, then timeout.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (en && sel_vld) begin
               state_d = BUS;
               gnt_d   = sel_idx;
               last_d  = sel_idx;
               cnt_d   = '0;
            end
         end
         BUS: begin
            if (!en || !cyc_g || wb_ack_i || at_last) begin
               state_d = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               // saturating: the counter can never wrap back to zero
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant, fairness pointer and timeout counter registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are gated combinationally so disable and abort act in the
   // same cycle; a simultaneous ack and timeout resolves to an ack.
   assign bus_act  = (state_q == BUS) && en;
   assign xfer     = bus_act && cyc_g;

   assign wb_cyc_o = xfer;
   assign wb_stb_o = xfer;
   assign wb_we_o  = xfer & we_mux;
   assign wb_adr_o = xfer ? adr_mux : 32'h0;
   assign wb_dat_o = xfer ? dat_mux : 32'h0;
   assign wb_sel_o = xfer ? sel_mux : 4'h0;

   assign m_ack_o  = (xfer && wb_ack_i) ? gnt_oh : '0;
   assign m_err_o  = (xfer && !wb_ack_i && at_last) ? gnt_oh : '0;
   assign m_dat_o  = wb_dat_i;

   assign grant_o  = bus_act ? gnt_oh : '0;
   assign busy_o   = bus_act;

endmodule
